// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory bus and decoder-facing signals of the fetch stage
interface fetch_unit_if #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 8
);
  logic [ADDR_SIZE-1:0] addr_bus, pc, pc_load_val;
  logic [DATA_SIZE-1:0] d_bus, instruction, imm_lo, imm_hi;
  logic [1:0] t_cycle, imm_cnt;
  logic rd, m1t1, cb_prefix, instr_valid, hold, pc_load;
  modport master (
    input d_bus, hold, imm_cnt, pc_load, pc_load_val,
    output addr_bus, rd, t_cycle, m1t1, instruction, cb_prefix, imm_lo, imm_hi, instr_valid, pc
  );
  modport slave (
    output d_bus, hold, imm_cnt, pc_load, pc_load_val,
    input addr_bus, rd, t_cycle, m1t1, instruction, cb_prefix, imm_lo, imm_hi, instr_valid, pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: 4-T-state opcode/immediate fetch feeding the decoder; FETCH_CB_PREFIX_EN enables the CB page
module fetch_unit #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [2:0] {
    S_OPCODE = 3'd0,
`ifdef FETCH_CB_PREFIX_EN
    S_CB = 3'd1,
`endif
    S_IMM1 = 3'd2,
    S_IMM2 = 3'd3,
    S_HOLD = 3'd4
  } state_t;
  state_t state, state_nx;
  logic run, done, t3, t4;
  logic [1:0] t_cycle;
  logic [ADDR_SIZE-1:0] pc;
  logic [DATA_SIZE-1:0] instruction, imm_lo, imm_hi;
  // run delays T1 of the first M-cycle to the first edge after reset release
  assign t3 = run && t_cycle == 2'd2;
  assign t4 = run && t_cycle == 2'd3;
  always_comb begin
    done = 1'b0;
    state_nx = S_IMM1;
    case (state)
`ifdef FETCH_CB_PREFIX_EN
      S_OPCODE: begin
        done = instruction != DATA_SIZE'('hCB) && bus.imm_cnt == 2'd0;
        state_nx = instruction == DATA_SIZE'('hCB) ? S_CB : S_IMM1;
      end
      S_CB: done = 1'b1;
`else
      S_OPCODE: done = bus.imm_cnt == 2'd0;
`endif
      S_IMM1: begin
        done = !bus.imm_cnt[1];
        state_nx = S_IMM2;
      end
      S_IMM2: done = 1'b1;
      default: state_nx = S_HOLD;
    endcase
    if (done || bus.pc_load || state == S_HOLD) state_nx = bus.hold ? S_HOLD : S_OPCODE;
    if (!t4) state_nx = state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_OPCODE;
      run <= 1'b0;
      t_cycle <= 2'd0;
      pc <= RESET_PC;
      instruction <= '0;
      imm_lo <= '0;
      imm_hi <= '0;
    end else begin
      state <= state_nx;
      run <= 1'b1;
      if (run) t_cycle <= t_cycle + 2'd1;
      if (t4 && (bus.pc_load || state != S_HOLD)) pc <= bus.pc_load ? bus.pc_load_val : pc + ADDR_SIZE'(1);
      if (t3 && state == S_OPCODE) instruction <= bus.d_bus;
`ifdef FETCH_CB_PREFIX_EN
      if (t3 && state == S_CB) instruction <= bus.d_bus;
`endif
      if (t3 && state == S_IMM1) imm_lo <= bus.d_bus;
      if (t3 && state == S_IMM2) imm_hi <= bus.d_bus;
    end
`ifdef FETCH_CB_PREFIX_EN
  logic cb_prefix;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cb_prefix <= 1'b0;
    else if (t3 && state == S_OPCODE) cb_prefix <= 1'b0;
    else if (t3 && state == S_CB) cb_prefix <= 1'b1;
  assign bus.cb_prefix = cb_prefix;
`else
  assign bus.cb_prefix = 1'b0;
`endif
  assign bus.addr_bus = pc;
  assign bus.pc = pc;
  assign bus.rd = run && state != S_HOLD && t_cycle != 2'd3;
  assign bus.m1t1 = run && state == S_OPCODE && t_cycle == 2'd0;
  assign bus.t_cycle = t_cycle;
  assign bus.instruction = instruction;
  assign bus.imm_lo = imm_lo;
  assign bus.imm_hi = imm_hi;
  assign bus.instr_valid = t4 && done;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch timing, immediates, CB page, hold, redirect and reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;
  fetch_unit_if bus ();
  fetch_unit_if bus2 ();
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
  always #5 clk = ~clk;
  function automatic logic [1:0] imm_of(input logic [7:0] op);
    return (op == 8'h3E || op == 8'h06) ? 2'd1 : (op == 8'hC3 || op == 8'h01) ? 2'd2 : 2'd0;
  endfunction
  assign bus.d_bus = mem[bus.addr_bus];
  assign bus.imm_cnt = imm_of(bus.instruction);
  assign bus2.d_bus = 8'h00;
  assign bus2.imm_cnt = 2'd0;
  assign bus2.hold = 1'b0;
  assign bus2.pc_load = 1'b0;
  assign bus2.pc_load_val = 16'h0000;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves the bench at the middle of clock 0 (T1 of the first M-cycle)
  task automatic do_reset();
    rst_n = 1'b0;
    bus.hold = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.hold = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = 16'h0000;
    step(2);
    checks++; if (bus.addr_bus !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", bus.addr_bus); end
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h exp 0000", bus.pc); end
    checks++; if (bus.rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %b exp 0", bus.rd); end
    checks++; if (bus.m1t1 !== 1'b0) begin errors++; $display("FAIL rst_m1t1 got %b exp 0", bus.m1t1); end
    checks++; if (bus.t_cycle !== 2'd0) begin errors++; $display("FAIL rst_t got %0d exp 0", bus.t_cycle); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid); end
    checks++; if ({bus.instruction, bus.imm_lo, bus.imm_hi, bus.cb_prefix} !== 25'h0) begin errors++; $display("FAIL rst_record got %h %h %h %b exp 00 00 00 0", bus.instruction, bus.imm_lo, bus.imm_hi, bus.cb_prefix); end
    checks++; if (bus2.addr_bus !== 16'hFFFF) begin errors++; $display("FAIL rst_addr2 got %h exp ffff", bus2.addr_bus); end
  endtask

  task automatic test_nop();
    logic [4:0] rd_exp = 5'b10111;
    logic [4:0] iv_exp = 5'b01000;
    logic [4:0] m1_exp = 5'b10001;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (bus.rd !== rd_exp[k] || bus.instr_valid !== iv_exp[k] || bus.m1t1 !== m1_exp[k] || bus.t_cycle !== 2'(k % 4))
        begin errors++; $display("FAIL nop_timing clk %0d got rd=%b iv=%b m1=%b t=%0d exp rd=%b iv=%b m1=%b t=%0d", k, bus.rd, bus.instr_valid, bus.m1t1, bus.t_cycle, rd_exp[k], iv_exp[k], m1_exp[k], k % 4); end
      if (k == 3) begin
        checks++; if (bus.instruction !== 8'h00) begin errors++; $display("FAIL nop_instr got %h exp 00", bus.instruction); end
      end
      if (k < 4) step(1);
    end
    checks++; if (bus.addr_bus !== 16'h0001) begin errors++; $display("FAIL nop_addr got %h exp 0001", bus.addr_bus); end
  endtask

  task automatic test_imm1();
    do_reset();
    mem[0] = 8'h3E; mem[1] = 8'h42;
    step(3);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL imm1_early_valid got %b exp 0", bus.instr_valid); end
    step(4);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL imm1_valid got %b exp 1", bus.instr_valid); end
    checks++; if (bus.instruction !== 8'h3E || bus.imm_lo !== 8'h42) begin errors++; $display("FAIL imm1_record got %h %h exp 3e 42", bus.instruction, bus.imm_lo); end
    step(1);
    checks++; if (bus.pc !== 16'h0002 || bus.m1t1 !== 1'b1) begin errors++; $display("FAIL imm1_pc got %h m1=%b exp 0002 m1=1", bus.pc, bus.m1t1); end
  endtask

  task automatic test_imm2_jump();
    do_reset();
    mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01; mem[16'h0150] = 8'h3E; mem[16'h0151] = 8'h99;
    step(11);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL jp_valid got %b exp 1", bus.instr_valid); end
    checks++; if ({bus.imm_hi, bus.imm_lo} !== 16'h0150 || bus.instruction !== 8'hC3) begin errors++; $display("FAIL jp_record got %h%h %h exp 0150 c3", bus.imm_hi, bus.imm_lo, bus.instruction); end
    bus.pc_load = 1'b1; bus.pc_load_val = 16'h0150;
    step(1);
    bus.pc_load = 1'b0;
    checks++; if (bus.addr_bus !== 16'h0150 || bus.m1t1 !== 1'b1 || bus.rd !== 1'b1) begin errors++; $display("FAIL jp_target got %h m1=%b rd=%b exp 0150 m1=1 rd=1", bus.addr_bus, bus.m1t1, bus.rd); end
    step(7);
    checks++; if (bus.instr_valid !== 1'b1 || bus.imm_lo !== 8'h99 || bus.imm_hi !== 8'h01) begin errors++; $display("FAIL keep_imm_hi got iv=%b %h %h exp iv=1 99 01", bus.instr_valid, bus.imm_lo, bus.imm_hi); end
  endtask

  task automatic test_pc_load();
    do_reset();
    mem[0] = 8'hC3; mem[1] = 8'hAA; mem[2] = 8'hBB;
    step(5);
    bus.pc_load = 1'b1; bus.pc_load_val = 16'h0300;
    step(1);
    bus.pc_load = 1'b0;
    step(1);
    checks++; if (bus.addr_bus !== 16'h0001 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL ld_non_t4 got %h iv=%b exp 0001 iv=0", bus.addr_bus, bus.instr_valid); end
    bus.pc_load = 1'b1; bus.pc_load_val = 16'h0200;
    step(1);
    bus.pc_load = 1'b0;
    checks++; if (bus.addr_bus !== 16'h0200 || bus.m1t1 !== 1'b1) begin errors++; $display("FAIL ld_discard got %h m1=%b exp 0200 m1=1", bus.addr_bus, bus.m1t1); end
    step(3);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instruction !== 8'h00) begin errors++; $display("FAIL ld_next got iv=%b %h exp iv=1 00", bus.instr_valid, bus.instruction); end
  endtask

  task automatic test_cb();
    do_reset();
    mem[0] = 8'hCB; mem[1] = 8'h37;
    step(3);
`ifdef FETCH_CB_PREFIX_EN
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL cb_early_valid got %b exp 0", bus.instr_valid); end
    step(1);
    checks++; if (bus.m1t1 !== 1'b0 || bus.rd !== 1'b1) begin errors++; $display("FAIL cb_second_fetch got m1=%b rd=%b exp m1=0 rd=1", bus.m1t1, bus.rd); end
    step(3);
    checks++; if (bus.instr_valid !== 1'b1 || bus.cb_prefix !== 1'b1 || bus.instruction !== 8'h37) begin errors++; $display("FAIL cb_record got iv=%b cb=%b %h exp iv=1 cb=1 37", bus.instr_valid, bus.cb_prefix, bus.instruction); end
`else
    checks++; if (bus.instr_valid !== 1'b1 || bus.cb_prefix !== 1'b0 || bus.instruction !== 8'hCB) begin errors++; $display("FAIL cb_plain got iv=%b cb=%b %h exp iv=1 cb=0 cb", bus.instr_valid, bus.cb_prefix, bus.instruction); end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    bus.hold = 1'b1;
    step(3);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", bus.instr_valid); end
    for (int k = 4; k <= 15; k++) begin
      step(1);
      checks++;
      if (bus.rd !== 1'b0 || bus.addr_bus !== 16'h0001 || bus.instr_valid !== 1'b0 || bus.m1t1 !== 1'b0)
        begin errors++; $display("FAIL hold_idle clk %0d got rd=%b addr=%h iv=%b m1=%b exp rd=0 addr=0001 iv=0 m1=0", k, bus.rd, bus.addr_bus, bus.instr_valid, bus.m1t1); end
      if (k == 5 || k == 12) bus.hold = 1'b0;
      if (k == 6) bus.hold = 1'b1;
    end
    step(1);
    checks++; if (bus.rd !== 1'b1 || bus.m1t1 !== 1'b1 || bus.addr_bus !== 16'h0001) begin errors++; $display("FAIL hold_resume got rd=%b m1=%b addr=%h exp rd=1 m1=1 addr=0001", bus.rd, bus.m1t1, bus.addr_bus); end
  endtask

  task automatic test_reset_pc();
    do_reset();
    checks++; if (bus2.addr_bus !== 16'hFFFF || bus2.rd !== 1'b1) begin errors++; $display("FAIL wrap_start got %h rd=%b exp ffff rd=1", bus2.addr_bus, bus2.rd); end
    step(3);
    checks++; if (bus2.instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", bus2.instr_valid); end
    step(1);
    checks++; if (bus2.addr_bus !== 16'h0000 || bus2.m1t1 !== 1'b1) begin errors++; $display("FAIL wrap_addr got %h m1=%b exp 0000 m1=1", bus2.addr_bus, bus2.m1t1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem[0] = 8'h3E; mem[1] = 8'h42;
    step(5);
    checks++; if (bus.instruction !== 8'h3E) begin errors++; $display("FAIL ar_pre got %h exp 3e", bus.instruction); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rd !== 1'b0 || bus.t_cycle !== 2'd0 || bus.addr_bus !== 16'h0000 || bus.instruction !== 8'h00 || bus.imm_lo !== 8'h00 || bus.m1t1 !== 1'b0)
      begin errors++; $display("FAIL ar_now got rd=%b t=%0d addr=%h %h %h m1=%b exp rd=0 t=0 addr=0000 00 00 m1=0", bus.rd, bus.t_cycle, bus.addr_bus, bus.instruction, bus.imm_lo, bus.m1t1); end
    step(3);
    checks++; if (bus.instr_valid !== 1'b0 || bus.rd !== 1'b0 || bus.imm_lo !== 8'h00) begin errors++; $display("FAIL ar_held got iv=%b rd=%b lo=%h exp iv=0 rd=0 lo=00", bus.instr_valid, bus.rd, bus.imm_lo); end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_nop();
    test_imm1();
    test_imm2_jump();
    test_pc_load();
    test_cb();
    test_hold();
    test_reset_pc();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
